// File: rtl/pkt_traffic_gen.sv
// Packet traffic generator: emits bursts of header+payload packets with directed
// or LFSR-random fields, honouring per-cycle downstream ready.
module pkt_traffic_gen #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          PORT_NUB_TOTAL  = 16,
  parameter int          PRIORITY        = 8,
  parameter int          DATA_LENGTH_MAX = 512,
  parameter int          TX_PORT         = 0,
  parameter int          IPG             = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               mode,
  input  logic [$clog2(PORT_NUB_TOTAL)-1:0]  dest,
  // `priority` is a reserved word in SystemVerilog
  input  logic [$clog2(PRIORITY)-1:0]        prio,
  input  logic [$clog2(DATA_LENGTH_MAX)-1:0] length,
  input  logic [7:0]                         burst_cnt,
  input  logic                               ready,
  output logic                               idle,
  output logic                               done,
  output logic                               wr_sop,
  output logic                               wr_eop,
  output logic                               wr_vld,
  output logic [DATA_WIDTH-1:0]              wr_data,
  output logic [15:0]                        pkt_cnt
);

  localparam int WS = $clog2(PORT_NUB_TOTAL);
  localparam int WP = $clog2(PRIORITY);
  localparam int WL = $clog2(DATA_LENGTH_MAX);
  localparam logic [15:0]   SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]   LEN_MAX16 = 16'(DATA_LENGTH_MAX - 1);
  localparam logic [WL-1:0] LEN_ONE   = 1;

  if (DATA_WIDTH < 32 || DATA_WIDTH < 16 + WL + WP + WS) begin : g_bad_width
    $error("pkt_traffic_gen: DATA_WIDTH too small for header fields");
  end
  if (WL > 16) begin : g_bad_len
    $error("pkt_traffic_gen: DATA_LENGTH_MAX exceeds 16-bit payload index");
  end
  if (TX_PORT < 0 || TX_PORT >= PORT_NUB_TOTAL) begin : g_bad_port
    $error("pkt_traffic_gen: TX_PORT out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_GAP} state_t;
  state_t state, state_nx;

  logic            mode_r;
  logic [WS-1:0]   cur_dest, rnd_dest;
  logic [WP-1:0]   cur_prio, rnd_prio;
  logic [WL-1:0]   cur_len, rnd_len, idx;
  logic [7:0]      rem;
  logic [15:0]     gap_cnt, lfsr, lfsr_nx, rnd_len_raw;
  logic            rand_now, emit, last_word, enter_head;
  logic [DATA_WIDTH-1:0] hdr_word, body_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    lfsr_nx     = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    rnd_dest    = lfsr_nx[WS-1:0];
    rnd_prio    = lfsr_nx[WS +: WP];
    rnd_len_raw = {8'h00, lfsr_nx[15:12], 4'h0} + 16'd15;
    if (rnd_len_raw > LEN_MAX16) rnd_len_raw = LEN_MAX16;
    rnd_len     = WL'(rnd_len_raw);

    rand_now   = (state == S_IDLE) ? mode : mode_r;
    emit       = ready && (state == S_HEAD || state == S_BODY);
    last_word  = emit && ((state == S_HEAD && cur_len == '0) ||
                          (state == S_BODY && idx == cur_len - LEN_ONE));
    state_nx   = state;
    enter_head = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nx   = S_HEAD;
        enter_head = 1'b1;
      end
      S_HEAD: if (emit && !last_word) state_nx = S_BODY;
      S_GAP:  if (gap_cnt == '0) begin
        state_nx   = S_HEAD;
        enter_head = 1'b1;
      end
      default: ;
    endcase
    if (last_word) begin
      if (rem <= 8'd1) begin
        state_nx = S_IDLE;
      end else if (IPG == 0) begin
        state_nx   = S_HEAD;
        enter_head = 1'b1;
      end else begin
        state_nx = S_GAP;
      end
    end

    hdr_word = '0;
    hdr_word[0 +: WS]            = cur_dest;
    hdr_word[WS +: WP]           = cur_prio;
    hdr_word[WS + WP +: WL]      = cur_len;
    hdr_word[WS + WP + WL +: 16] = pkt_cnt;
    body_word = '0;
    body_word[15:0]  = 16'(idx);
    body_word[31:16] = pkt_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 1'b0;
      cur_dest <= '0;
      cur_prio <= '0;
      cur_len  <= '0;
      idx      <= '0;
      rem      <= '0;
      gap_cnt  <= '0;
      lfsr     <= SEED_EFF;
      pkt_cnt  <= '0;
      wr_sop   <= 1'b0;
      wr_eop   <= 1'b0;
      wr_vld   <= 1'b0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_r <= mode;
        rem    <= (burst_cnt == 8'd0) ? 8'd1 : burst_cnt;
      end
      // Directed fields are captured once per burst; random ones refresh per packet.
      if (enter_head) begin
        if (rand_now) begin
          lfsr     <= lfsr_nx;
          cur_dest <= rnd_dest;
          cur_prio <= rnd_prio;
          cur_len  <= rnd_len;
        end else if (state == S_IDLE) begin
          cur_dest <= dest;
          cur_prio <= prio;
          cur_len  <= length;
        end
      end
      if (emit) idx <= (state == S_HEAD) ? '0 : idx + LEN_ONE;
      if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
      if (last_word) begin
        rem     <= rem - 8'd1;
        pkt_cnt <= pkt_cnt + 16'd1;
        gap_cnt <= 16'((IPG > 0) ? IPG - 1 : 0);
      end
      wr_vld  <= emit;
      wr_sop  <= emit && (state == S_HEAD);
      wr_eop  <= last_word;
      done    <= last_word && (rem <= 8'd1);
      wr_data <= emit ? ((state == S_HEAD) ? hdr_word : body_word) : '0;
    end
  end

  assign idle = (state == S_IDLE);

endmodule
